// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT front end: sizing defaults, loader
// state encoding and the bit-reversal used to scatter natural-order samples.
package fft_pkg;

  localparam int BIT_WIDTH_DEF = 16;
  localparam int N_POINT_DEF   = 64;
  localparam int LOG2N_DEF     = 6;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Reverses the low log2n bits of k; bits at and above log2n come back as 0.
  function automatic logic [31:0] bitrev(input logic [31:0] k, input int log2n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < log2n) r[i] = k[log2n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pair_bank.sv
// Dual-bank sample store: one write port addressed by the bit-reversed index,
// and a combinational read of the same row from both banks.
module fft_pair_bank
  import fft_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH_DEF,
  parameter int LOG2N     = LOG2N_DEF
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [LOG2N-1:0]       wr_addr,
  input  logic [bit_width-1:0]   wr_re,
  input  logic [bit_width-1:0]   wr_im,
  input  logic [LOG2N-2:0]       rd_row,
  output logic [2*bit_width-1:0] even_word,
  output logic [2*bit_width-1:0] odd_word
);

  localparam int HALF = 2 ** (LOG2N - 1);

  logic [2*bit_width-1:0] even_mem [HALF];
  logic [2*bit_width-1:0] odd_mem  [HALF];

  // Bit 0 of the reversed address picks the bank, the rest is the row.
  always_ff @(posedge clk) begin
    if (we && !wr_addr[0]) even_mem[wr_addr[LOG2N-1:1]] <= {wr_re, wr_im};
    if (we &&  wr_addr[0]) odd_mem[wr_addr[LOG2N-1:1]]  <= {wr_re, wr_im};
  end

  assign even_word = even_mem[rd_row];
  assign odd_word  = odd_mem[rd_row];

endmodule

// File: rtl/fft_bitrev_loader.sv
// Collects one natural-order frame into bit-reversed storage, then streams the
// first-stage butterfly operand pairs (x[2p], x[2p+1]) downstream.
module fft_bitrev_loader
  import fft_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH_DEF,
  parameter int N_POINT   = N_POINT_DEF,
  parameter int LOG2N     = LOG2N_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [bit_width-1:0] in_re,
  input  logic signed [bit_width-1:0] in_im,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [bit_width-1:0] Re_o1,
  output logic signed [bit_width-1:0] Im_o1,
  output logic signed [bit_width-1:0] Re_o2,
  output logic signed [bit_width-1:0] Im_o2,
  output logic [LOG2N-2:0]            pair_idx,
  output logic                        frame_done
);

  if (N_POINT < 4 || (2 ** LOG2N) != N_POINT) begin : g_bad_param
    $error("fft_bitrev_loader: N_POINT must equal 2**LOG2N and be at least 4");
  end

  localparam int HALF = N_POINT / 2;
  localparam logic [LOG2N-1:0] K_LAST    = LOG2N'(N_POINT - 1);
  localparam logic [LOG2N-2:0] PAIR_LAST = (LOG2N-1)'(HALF - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never depends on ready, and data holds while valid & !ready.
  state_e state, next_state;
  logic [LOG2N-1:0]       k;
  logic [LOG2N-1:0]       p;
  logic [LOG2N-1:0]       wr_addr;
  logic [2*bit_width-1:0] even_word, odd_word;
  logic                   in_fire, out_fire, load_out, last_fire;

  assign in_ready = rst_n && (state == LOAD);
  assign wr_addr  = LOG2N'(bitrev(32'(k), LOG2N));

  fft_pair_bank #(.bit_width(bit_width), .LOG2N(LOG2N)) u_bank (
    .clk       (clk),
    .we        (in_fire),
    .wr_addr   (wr_addr),
    .wr_re     (in_re),
    .wr_im     (in_im),
    .rd_row    (p[LOG2N-2:0]),
    .even_word (even_word),
    .odd_word  (odd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_fire    = 1'b0;
    load_out   = 1'b0;
    last_fire  = 1'b0;
    out_fire   = out_valid && out_ready;
    unique case (state)
      LOAD: begin
        in_fire = in_valid;
        if (in_valid && k == K_LAST) next_state = DRAIN;
      end
      DRAIN: begin
        // p reaching HALF (top bit set) means every pair has been issued.
        load_out  = (!out_valid || out_ready) && !p[LOG2N-1];
        last_fire = out_fire && pair_idx == PAIR_LAST;
        if (last_fire) next_state = LOAD;
      end
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k          <= '0;
      p          <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      Re_o1      <= '0;
      Im_o1      <= '0;
      Re_o2      <= '0;
      Im_o2      <= '0;
      pair_idx   <= '0;
    end else begin
      frame_done <= last_fire;
      // k wraps to 0 on the last sample because N_POINT is a power of two.
      if (in_fire) k <= k + 1'b1;
      if (load_out) begin
        {Re_o1, Im_o1} <= even_word;
        {Re_o2, Im_o2} <= odd_word;
        pair_idx       <= p[LOG2N-2:0];
        out_valid      <= 1'b1;
        p              <= p + 1'b1;
      end else if (last_fire) begin
        out_valid <= 1'b0;
        p         <= '0;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Directed bench: an 8-point loader for ramp/stall/gap/extreme/reset cases and
// a 64-point loader for back-to-back frames.
module tb_fft_bitrev_loader;

  localparam int BW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-point instance
  logic          in_valid = 1'b0, out_ready = 1'b1;
  logic          in_ready, out_valid, frame_done;
  logic [BW-1:0] in_re = '0, in_im = '0;
  logic [BW-1:0] re_o1, im_o1, re_o2, im_o2;
  logic [1:0]    pair_idx;

  // 64-point instance
  logic          in_valid_b = 1'b0, out_ready_b = 1'b1;
  logic          in_ready_b, out_valid_b, frame_done_b;
  logic [BW-1:0] in_re_b = '0, in_im_b = '0;
  logic [BW-1:0] re_o1_b, im_o1_b, re_o2_b, im_o2_b;
  logic [4:0]    pair_idx_b;

  fft_bitrev_loader #(.bit_width(BW), .N_POINT(8), .LOG2N(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .Re_o1(re_o1), .Im_o1(im_o1), .Re_o2(re_o2), .Im_o2(im_o2),
    .pair_idx(pair_idx), .frame_done(frame_done)
  );

  fft_bitrev_loader #(.bit_width(BW), .N_POINT(64), .LOG2N(6)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_re(in_re_b), .in_im(in_im_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .Re_o1(re_o1_b), .Im_o1(im_o1_b), .Re_o2(re_o2_b), .Im_o2(im_o2_b),
    .pair_idx(pair_idx_b), .frame_done(frame_done_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Natural-order frame and the hand-derived 3-bit reversal table.
  logic [BW-1:0] fre [8];
  logic [BW-1:0] fim [8];
  int br8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic [BW-1:0] bre [64];
  logic [BW-1:0] bim [64];

  function automatic int brv(input int v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic load8(input bit gaps);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("ld_ready", in_ready, 1);
      in_valid = 1'b1;
      in_re    = fre[k];
      in_im    = fim[k];
      @(posedge clk);
      if (gaps && k != 7) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_re    = 16'h5555;
        @(posedge clk);
      end
    end
  endtask

  // Starts right after the edge that accepted sample 7.
  task automatic drain8(input int stall_p, input bit hold_valid, input int stop_after);
    @(negedge clk);
    in_valid = hold_valid;
    in_re    = 16'hDEAD;
    in_im    = 16'hBEEF;
    check("lat_one_edge_valid", out_valid, 0);
    check("drain_ready", in_ready, 0);
    for (int p = 0; p < 4; p++) begin
      @(posedge clk);
      @(negedge clk);
      exp_q.push_back(fre[br8[2*p]]);
      exp_q.push_back(fim[br8[2*p]]);
      exp_q.push_back(fre[br8[2*p+1]]);
      exp_q.push_back(fim[br8[2*p+1]]);
      check("pair_valid", out_valid, 1);
      check("re_o1", re_o1, exp_q.pop_front());
      check("im_o1", im_o1, exp_q.pop_front());
      check("re_o2", re_o2, exp_q.pop_front());
      check("im_o2", im_o2, exp_q.pop_front());
      check("pair_idx", pair_idx, p);
      check("pair_ready_low", in_ready, 0);
      if (p == stall_p) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          @(negedge clk);
          check("stall_valid", out_valid, 1);
          check("stall_re_o1", re_o1, fre[br8[2*p]]);
          check("stall_re_o2", re_o2, fre[br8[2*p+1]]);
          check("stall_idx", pair_idx, p);
          check("stall_done", frame_done, 0);
        end
        out_ready = 1'b1;
      end
      if (p == 3) in_valid = 1'b0;
      if (p == stop_after) return;
    end
    @(posedge clk);
    @(negedge clk);
    check("frame_done_hi", frame_done, 1);
    check("done_in_ready", in_ready, 1);
    check("done_valid_lo", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("frame_done_pulse", frame_done, 0);
    check("idle_valid_lo", out_valid, 0);
  endtask

  task automatic run64(input int f, inout int frames);
    int got  = 0;
    bit done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      bre[k] = 16'(k + f * 256);
      bim[k] = 16'(16'hFFFF - k - f);
    end
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      check("b_ld_ready", in_ready_b, 1);
      in_valid_b = 1'b1;
      in_re_b    = bre[k];
      in_im_b    = bim[k];
      @(posedge clk);
    end
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      in_valid_b = 1'b0;
      if (frame_done_b) begin
        done = 1'b1;
        frames++;
        check("b_done_ready", in_ready_b, 1);
      end else begin
        check("b_drain_ready", in_ready_b, 0);
        if (out_valid_b) begin
          check("b_idx", pair_idx_b, got);
          check("b_re_o1", re_o1_b, bre[brv(2*got, 6)]);
          check("b_im_o1", im_o1_b, bim[brv(2*got, 6)]);
          check("b_re_o2", re_o2_b, bre[brv(2*got+1, 6)]);
          check("b_im_o2", im_o2_b, bim[brv(2*got+1, 6)]);
          got++;
        end
      end
    end
    check("b_pairs", got, 32);
    check("b_done_seen", done, 1);
  endtask

  // ---------------- sequence ----------------
  initial begin
    int frames64 = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_done", frame_done, 0);
    check("rst_re_o1", re_o1, 0);
    check("rst_idx", pair_idx, 0);
    check("rst_ready_in_reset", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", in_ready, 1);
    check("rel_valid", out_valid, 0);

    // ramp, free-flowing
    for (int k = 0; k < 8; k++) begin
      fre[k] = 16'(k);
      fim[k] = 16'(-k);
    end
    load8(1'b0);
    drain8(-1, 1'b0, -1);

    // same frame with a three-cycle stall on pair 1
    load8(1'b0);
    drain8(1, 1'b0, -1);

    // gapped input, then in_valid held high through DRAIN
    load8(1'b1);
    drain8(-1, 1'b1, -1);

    // full-scale extremes
    for (int k = 0; k < 8; k++) begin
      fre[k] = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
      fim[k] = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
    end
    load8(1'b0);
    drain8(-1, 1'b0, -1);

    // reset while pair 1 is on the output
    for (int k = 0; k < 8; k++) begin
      fre[k] = 16'(3 * k + 1);
      fim[k] = 16'(k + 16);
    end
    load8(1'b0);
    drain8(-1, 1'b0, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_re_o1", re_o1, 0);
    check("mid_rst_im_o1", im_o1, 0);
    check("mid_rst_re_o2", re_o2, 0);
    check("mid_rst_im_o2", im_o2, 0);
    check("mid_rst_idx", pair_idx, 0);
    check("mid_rst_done", frame_done, 0);
    check("mid_rst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      fre[k] = 16'(100 + k);
      fim[k] = 16'(200 - k);
    end
    load8(1'b0);
    drain8(-1, 1'b0, -1);

    // 64-point, two frames back to back
    run64(0, frames64);
    run64(1, frames64);
    check("b_frames", frames64, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
